// File: rtl/aes_cipher_iter_if.sv
// rtl/aes_cipher_iter_if.sv - Handshake and key-schedule bundle for aes_cipher_iter
// Signals:
//   in_valid/in_ready/input_bytes : plaintext handshake (byte 0 at [127:120])
//   ExpandedKeys                  : round-key schedule, round key 0 at MSB end
//   out/out_valid/out_ready       : ciphertext handshake
//   busy                          : round computation in progress
// Modports: master drives plaintext, keys and out_ready; slave is the core.
interface aes_cipher_iter_if #(
  parameter int NR = 10
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [127:0]          input_bytes;
  logic [128*(NR+1)-1:0] ExpandedKeys;
  logic [127:0]          out;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;

  modport master (
    output in_valid, input_bytes, ExpandedKeys, out_ready,
    input  in_ready, out, out_valid, busy
  );

  modport slave (
    input  in_valid, input_bytes, ExpandedKeys, out_ready,
    output in_ready, out, out_valid, busy
  );
endinterface

// File: rtl/aes_cipher_iter.sv
// rtl/aes_cipher_iter.sv - Iterative AES encryption core, one round per clock
// Ports:
//   clk         : clock
//   reset       : asynchronous, active-high reset
//   bus (slave) : plaintext handshake (in_valid/in_ready/input_bytes),
//                 key schedule ExpandedKeys (not latched; hold stable while
//                 a block is in flight), ciphertext handshake
//                 (out/out_valid/out_ready) and busy.
// Parameters:
//   NR : number of rounds (10/12/14)
//   NK : key length in 32-bit words, paired with NR (NR = NK + 6)
module aes_cipher_iter #(
  parameter int NR = 10,
  parameter int NK = 4
) (
  input logic              clk,
  input logic              reset,
  aes_cipher_iter_if.slave bus
);

  localparam int            RW       = $clog2(NR + 1);
  localparam int            KW       = 128 * (NR + 1);
  localparam logic [RW-1:0] RND_ONE  = RW'(1);
  localparam logic [RW-1:0] RND_LAST = RW'(NR);

  // A mismatched NK/NR pair shows up as this named scope in elaboration.
  if (NR != NK + 6) begin : g_nk_nr_mismatch
  end

  // Forward S-box, index 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  // State byte k (column-major) lives at bits [127-8k -: 8].
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) begin
      r[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
    end
    return r;
  endfunction

  // Row r of the output takes column (c + r) mod 4 of the input.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  fsm_e          fsm_q, fsm_d;
  logic [127:0]  state_q, state_d;
  logic [RW-1:0] rnd_q, rnd_d;
  logic [127:0]  out_q, out_d;

  // Round-key table padded to a power of two so any counter value indexes
  // a defined entry; the pad entries are never selected in operation.
  logic [127:0] rk [2**RW];

  for (genvar r = 0; r < 2**RW; r++) begin : g_rk
    if (r <= NR) begin : g_used
      assign rk[r] = bus.ExpandedKeys[KW-1-128*r -: 128];
    end else begin : g_pad
      assign rk[r] = '0;
    end
  end

  logic [127:0] sr_w;
  logic [127:0] mc_w;
  logic [127:0] rk_cur;

  assign sr_w   = shift_rows(sub_bytes(state_q));
  assign mc_w   = mix_columns(sr_w);
  assign rk_cur = rk[rnd_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
      out_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    out_d   = out_q;
    case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = bus.input_bytes ^ rk[0];
          rnd_d   = RND_ONE;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        if (rnd_q == RND_LAST) begin
          // Final round skips MixColumns; the counter parks at NR.
          out_d = sr_w ^ rk_cur;
          fsm_d = DONE;
        end else begin
          state_d = mc_w ^ rk_cur;
          rnd_d   = rnd_q + RND_ONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            // Handshake out and accept the next block on the same edge.
            state_d = bus.input_bytes ^ rk[0];
            rnd_d   = RND_ONE;
            fsm_d   = ROUND;
          end else begin
            rnd_d = '0;
            fsm_d = IDLE;
          end
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // in_ready depends only on FSM state and out_ready, never on in_valid.
  assign bus.in_ready  = (fsm_q == IDLE) || ((fsm_q == DONE) && bus.out_ready);
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.busy      = (fsm_q == ROUND);
  assign bus.out       = out_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb/tb_aes_cipher_iter.sv - Directed-vector self-checking bench for aes_cipher_iter
module tb_aes_cipher_iter;

  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_cipher_iter_if #(.NR(10)) if10 ();
  aes_cipher_iter_if #(.NR(12)) if12 ();
  aes_cipher_iter_if #(.NR(14)) if14 ();

  aes_cipher_iter #(.NR(10), .NK(4)) dut10 (.clk(clk), .reset(reset), .bus(if10.slave));
  aes_cipher_iter #(.NR(12), .NK(6)) dut12 (.clk(clk), .reset(reset), .bus(if12.slave));
  aes_cipher_iter #(.NR(14), .NK(8)) dut14 (.clk(clk), .reset(reset), .bus(if14.slave));

  logic         iv_v [3];
  logic         or_v [3];
  logic [127:0] pt_v [3];
  logic [1407:0] ek10;
  logic [1663:0] ek12;
  logic [1919:0] ek14;

  assign if10.in_valid = iv_v[0];  assign if10.out_ready = or_v[0];
  assign if12.in_valid = iv_v[1];  assign if12.out_ready = or_v[1];
  assign if14.in_valid = iv_v[2];  assign if14.out_ready = or_v[2];
  assign if10.input_bytes = pt_v[0];
  assign if12.input_bytes = pt_v[1];
  assign if14.input_bytes = pt_v[2];
  assign if10.ExpandedKeys = ek10;
  assign if12.ExpandedKeys = ek12;
  assign if14.ExpandedKeys = ek14;

  logic         ov_s [3];
  logic         ir_s [3];
  logic         bz_s [3];
  logic [127:0] out_s [3];
  assign ov_s[0] = if10.out_valid; assign ir_s[0] = if10.in_ready; assign bz_s[0] = if10.busy; assign out_s[0] = if10.out;
  assign ov_s[1] = if12.out_valid; assign ir_s[1] = if12.in_ready; assign bz_s[1] = if12.busy; assign out_s[1] = if12.out;
  assign ov_s[2] = if14.out_valid; assign ir_s[2] = if14.in_ready; assign bz_s[2] = if14.busy; assign out_s[2] = if14.out;

  int vecs = 0;
  int errs = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // GF(2^8) arithmetic for an independent S-box used by the key expansion.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Key schedule packed MSB-first: word i at [1919-32i -: 32].
  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1919:0] res;
    res  = '0;
    rcon = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
          rcon = gmul(rcon, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          t = subword(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      res[1919-32*i -: 32] = w[i];
    end
    return res;
  endfunction

  task automatic load_key(input int k, input logic [255:0] key, input int nk);
    logic [1919:0] full;
    full = expand(key, nk, 10 + 2 * k);
    case (k)
      0:       ek10 = full[1919 -: 1408];
      1:       ek12 = full[1919 -: 1664];
      default: ek14 = full;
    endcase
  endtask

  // Returns at the falling edge right after the accept edge.
  task automatic submit(input int k, input logic [127:0] pt, input bit hold);
    @(negedge clk);
    pt_v[k] = pt;
    iv_v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) iv_v[k] = 1'b0;
  endtask

  // Counts clock edges since the accept edge until out_valid is seen.
  task automatic wait_out(input int k, input int n0, output int n);
    n = n0;
    while (!ov_s[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  typedef struct packed {
    logic [1:0]   idx;
    logic [3:0]   nk;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    logic         chk_r1;
  } vec_t;

  vec_t vt [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    vt[0] = '{idx: 2'd0, nk: 4'd4, key: KEY_C1, pt: PT_C, ct: CT_C1, chk_r1: 1'b0};
    vt[1] = '{idx: 2'd0, nk: 4'd4, key: KEY_B,  pt: PT_B, ct: CT_B,  chk_r1: 1'b1};
    vt[2] = '{idx: 2'd1, nk: 4'd6, key: KEY_C2, pt: PT_C, ct: CT_C2, chk_r1: 1'b0};
    vt[3] = '{idx: 2'd2, nk: 4'd8, key: KEY_C3, pt: PT_C, ct: CT_C3, chk_r1: 1'b0};

    for (int k = 0; k < 3; k++) begin
      iv_v[k] = 1'b0;
      or_v[k] = 1'b1;
      pt_v[k] = '0;
    end
    ek10 = '0; ek12 = '0; ek14 = '0;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_out_valid", 128'(ov_s[k]), 128'd0);
      check("reset_busy",      128'(bz_s[k]), 128'd0);
      check("reset_in_ready",  128'(ir_s[k]), 128'd1);
      check("reset_out",       out_s[k],      128'd0);
    end
    reset = 1'b0;

    for (int v = 0; v < 4; v++) begin
      int k;
      k = int'(vt[v].idx);
      load_key(k, vt[v].key, int'(vt[v].nk));
      submit(k, vt[v].pt, 1'b0);
      n = 0;
      if (vt[v].chk_r1) begin
        check("appb_round1_start", dut10.state_q, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        @(negedge clk);
        n = 1;
        check("appb_round2_start", dut10.state_q, 128'ha49c7ff2689f352b6b5bea43026a5049);
      end
      wait_out(k, n, n);
      check("latency",    128'(n), 128'(10 + 2 * k));
      check("ciphertext", out_s[k], vt[v].ct);
      @(negedge clk);
      check("out_valid_dropped", 128'(ov_s[k]), 128'd0);
      check("out_kept",          out_s[k],      vt[v].ct);
      check("in_ready_idle",     128'(ir_s[k]), 128'd1);
    end

    // Backpressure with in_valid held high, then back-to-back accept.
    load_key(0, KEY_C1, 4);
    or_v[0] = 1'b0;
    submit(0, PT_C, 1'b1);
    pt_v[0] = PT_B;
    wait_out(0, 0, n);
    check("bp_latency", 128'(n), 128'd10);
    load_key(0, KEY_B, 4);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_stable",  out_s[0],      CT_C1);
      check("bp_out_valid",   128'(ov_s[0]), 128'd1);
      check("bp_in_ready",    128'(ir_s[0]), 128'd0);
      @(negedge clk);
    end
    or_v[0] = 1'b1;
    #1;
    check("b2b_in_ready", 128'(ir_s[0]), 128'd1);
    @(posedge clk);
    @(negedge clk);
    iv_v[0] = 1'b0;
    check("b2b_out_valid_low", 128'(ov_s[0]), 128'd0);
    check("b2b_busy",          128'(bz_s[0]), 128'd1);
    wait_out(0, 0, n);
    check("b2b_latency",    128'(n), 128'd10);
    check("b2b_ciphertext", out_s[0], CT_B);
    @(negedge clk);

    // Plaintext offered during ROUND must be ignored.
    submit(0, PT_B, 1'b0);
    repeat (3) @(negedge clk);
    pt_v[0] = PT_C;
    iv_v[0] = 1'b1;
    @(negedge clk);
    iv_v[0] = 1'b0;
    wait_out(0, 4, n);
    check("ign_latency",    128'(n), 128'd10);
    check("ign_ciphertext", out_s[0], CT_B);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ov_s[0]) pulses++;
    end
    check("ign_no_extra_output", 128'(pulses), 128'd0);
    check("ign_out_kept",        out_s[0],     CT_B);

    // Reset during round 5 aborts the block.
    load_key(0, KEY_C1, 4);
    submit(0, PT_C, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_out",       out_s[0],      128'd0);
    check("midrst_out_valid", 128'(ov_s[0]), 128'd0);
    check("midrst_busy",      128'(bz_s[0]), 128'd0);
    check("midrst_in_ready",  128'(ir_s[0]), 128'd1);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ov_s[0]) pulses++;
    end
    check("midrst_no_output", 128'(pulses), 128'd0);
    submit(0, PT_C, 1'b0);
    wait_out(0, 0, n);
    check("midrst_latency",    128'(n), 128'd10);
    check("midrst_ciphertext", out_s[0], CT_C1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
